// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Results are computed at issue, held as pending, and committed on the last busy cycle.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic             p_wr;
    logic             md_start;

    logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   mag_a, mag_b, quo_mag, rem_mag, quo_s, rem_s;
    logic [WIDTH-1:0]   divu_b, quo_u, rem_u;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic               res_wr;
    logic [CW-1:0]      cnt_load;

    assign md_start = start && (md_op >= OP_MULT) && (md_op <= OP_DIVU);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (md_start) state_next = RUN;
            RUN:     if (cnt == CNT_ONE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: stall_req covers both the in-flight op and a new md op arriving now
    always_comb begin
        busy      = (state == RUN);
        stall_req = (state == RUN) || md_start;
    end

    // Multiply: sign/zero extend to 2*WIDTH so the truncated product is exact
    assign a_sx   = {{WIDTH{src_a[WIDTH-1]}}, src_a};
    assign b_sx   = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign a_zx   = {{WIDTH{1'b0}}, src_a};
    assign b_zx   = {{WIDTH{1'b0}}, src_b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    // Signed divide via magnitudes; INT_MIN/-1 wraps back to INT_MIN with remainder 0.
    // A zero divisor is replaced by 1 only to keep the divider defined; its result is never committed.
    assign a_neg   = src_a[WIDTH-1];
    assign b_neg   = src_b[WIDTH-1];
    assign mag_a   = a_neg ? ('0 - src_a) : src_a;
    assign mag_b   = (src_b == '0) ? WIDTH'(1) : (b_neg ? ('0 - src_b) : src_b);
    assign quo_mag = mag_a / mag_b;
    assign rem_mag = mag_a % mag_b;
    assign quo_s   = (a_neg ^ b_neg) ? ('0 - quo_mag) : quo_mag;
    assign rem_s   = a_neg ? ('0 - rem_mag) : rem_mag;
    assign divu_b  = (src_b == '0) ? WIDTH'(1) : src_b;
    assign quo_u   = src_a / divu_b;
    assign rem_u   = src_a % divu_b;

    always_comb begin
        res_hi   = '0;
        res_lo   = '0;
        res_wr   = 1'b1;
        cnt_load = MULT_LOAD;
        case (md_op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                res_hi   = rem_s;
                res_lo   = quo_s;
                res_wr   = (src_b != '0);
                cnt_load = DIV_LOAD;
            end
            OP_DIVU: begin
                res_hi   = rem_u;
                res_lo   = quo_u;
                res_wr   = (src_b != '0);
                cnt_load = DIV_LOAD;
            end
            default: res_wr = 1'b0;
        endcase
    end

    // Datapath: starts are accepted only in IDLE; RUN ignores all new requests
    always_ff @(posedge clk) begin
        if (reset) begin
            hi   <= '0;
            lo   <= '0;
            cnt  <= '0;
            p_hi <= '0;
            p_lo <= '0;
            p_wr <= 1'b0;
        end else if (state == IDLE) begin
            if (md_start) begin
                p_hi <= res_hi;
                p_lo <= res_lo;
                p_wr <= res_wr;
                cnt  <= cnt_load;
            end else if (start && md_op == OP_MTHI) begin
                hi <= src_a;
            end else if (start && md_op == OP_MTLO) begin
                lo <= src_a;
            end
        end else begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE && p_wr) begin
                hi <= p_hi;
                lo <= p_lo;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed spec scenarios plus random ops, checked every cycle
// against a remaining-cycles reference model using 64-bit arithmetic.
module tb_md_unit;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   md_op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         busy;
    logic         stall_req;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_hi, m_lo, m_ph, m_pl;
    int           m_left;
    bit           m_pw;

    md_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .stall_req(stall_req),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic md_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] rh, output logic [W-1:0] rl, output bit wr);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        logic [63:0]     v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        rh = '0;
        rl = '0;
        wr = 1'b1;
        case (op)
            3'd1: begin v = 64'(sa * sb); rh = v[63:32]; rl = v[31:0]; end
            3'd2: begin up = ua * ub; v = up; rh = v[63:32]; rl = v[31:0]; end
            3'd3: if (b == '0) wr = 1'b0;
                  else begin
                      sq = sa / sb; sr = sa % sb;
                      v = 64'(sq); rl = v[31:0];
                      v = 64'(sr); rh = v[31:0];
                  end
            3'd4: if (b == '0) wr = 1'b0;
                  else begin
                      v = ua / ub; rl = v[31:0];
                      v = ua % ub; rh = v[31:0];
                  end
            default: wr = 1'b0;
        endcase
    endtask

    task automatic model_step(input bit r, input bit s, input logic [2:0] op,
                              input logic [W-1:0] a, input logic [W-1:0] b);
        if (r) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_pw = 1'b0; m_ph = '0; m_pl = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_pw) begin m_hi = m_ph; m_lo = m_pl; end
        end else if (s) begin
            if (op >= 3'd1 && op <= 3'd4) begin
                md_ref(op, a, b, m_ph, m_pl, m_pw);
                m_left = (op >= 3'd3) ? DC : MC;
            end else if (op == 3'd5) m_hi = a;
            else if (op == 3'd6) m_lo = a;
        end
    endtask

    // One clock: drive at negedge, check registered and comb outputs, then advance the model
    task automatic cycle(input bit r, input bit s, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        bit exp_stall;
        @(negedge clk);
        reset = r; start = s; md_op = op; src_a = a; src_b = b;
        #1;
        exp_stall = (m_left > 0) || (s && op >= 3'd1 && op <= 3'd4);
        if (!r) begin
            check("busy", W'(busy), W'(m_left > 0));
            check("stall_req", W'(stall_req), W'(exp_stall));
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
        @(posedge clk);
        model_step(r, s, op, a, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, '0, '0);
    endtask

    // Look at outputs just after an edge without consuming a cycle
    task automatic peek(input string tag, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input bit exp_busy);
        #2;
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_busy"}, W'(busy), W'(exp_busy));
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] edges[6];
        edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        case ($urandom_range(0, 3))
            0:       return edges[$urandom_range(0, 5)];
            1:       return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; md_op = '0; src_a = '0; src_b = '0;
        model_step(1'b1, 1'b0, 3'd0, '0, '0);

        // Reset, then idle with everything quiet
        cycle(1'b1, 1'b1, 3'd1, 32'h5, 32'h7);
        cycle(1'b1, 1'b0, 3'd0, '0, '0);
        peek("reset", 32'h0, 32'h0, 1'b0);
        idle(3);

        // mult / multu, busy exactly MC cycles
        cycle(1'b0, 1'b1, 3'd1, 32'hFFFF_FFFF, 32'h2);
        idle(MC - 1);
        peek("mult_run", 32'h0, 32'h0, 1'b1);
        idle(1);
        peek("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        cycle(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'h2);
        idle(MC);
        peek("multu", 32'h1, 32'hFFFF_FFFE, 1'b0);

        // divides including INT_MIN / -1
        cycle(1'b0, 1'b1, 3'd3, 32'hFFFF_FFF9, 32'h2);
        idle(DC);
        peek("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        cycle(1'b0, 1'b1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DC);
        peek("divu", 32'h8000_0000, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        idle(DC);
        peek("div_ovf", 32'h0, 32'h8000_0000, 1'b0);

        // mthi in idle; mtlo during busy is dropped
        cycle(1'b0, 1'b1, 3'd5, 32'h1234, 32'h0);
        peek("mthi", 32'h1234, 32'h8000_0000, 1'b0);
        cycle(1'b0, 1'b1, 3'd1, 32'h3, 32'h4);
        cycle(1'b0, 1'b1, 3'd6, 32'hDEAD, 32'h0);
        idle(MC - 2);
        peek("mtlo_drop", 32'h1234, 32'h8000_0000, 1'b1);
        idle(1);
        peek("mult_after", 32'h0, 32'hC, 1'b0);

        // divide by zero leaves hi/lo alone
        cycle(1'b0, 1'b1, 3'd5, 32'hAA, 32'h0);
        cycle(1'b0, 1'b1, 3'd6, 32'hBB, 32'h0);
        cycle(1'b0, 1'b1, 3'd3, 32'h5, 32'h0);
        idle(DC - 1);
        peek("div0_run", 32'hAA, 32'hBB, 1'b1);
        idle(1);
        peek("div0", 32'hAA, 32'hBB, 1'b0);

        // reserved / none ops do nothing
        cycle(1'b0, 1'b1, 3'd7, 32'h55, 32'h66);
        cycle(1'b0, 1'b1, 3'd0, 32'h55, 32'h66);
        peek("rsvd", 32'hAA, 32'hBB, 1'b0);

        // reset mid-run discards the pending result
        cycle(1'b0, 1'b1, 3'd2, 32'h10, 32'h10);
        idle(1);
        cycle(1'b1, 1'b0, 3'd0, '0, '0);
        peek("rst_mid", 32'h0, 32'h0, 1'b0);
        idle(MC + 2);
        peek("rst_nowrite", 32'h0, 32'h0, 1'b0);

        // random traffic, including starts while busy and occasional resets
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0,
                  3'($urandom_range(0, 7)), pick_operand(), pick_operand());
        end
        idle(DC + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
